// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width derivation and threshold defaults for sync_fifo
package fifo_pkg;

  localparam int DEFAULT_WIDTH             = 8;
  localparam int DEFAULT_DEPTH             = 512;
  localparam int DEFAULT_ALMOST_EMPTY_TH   = 2;
  localparam int DEFAULT_ALMOST_FULL_MARGIN = 2;

  // Pointer width: pointers wrap naturally at the power-of-two depth.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Count needs one extra bit so that "depth" itself is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - request/response bundle between a FIFO user and sync_fifo
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEFAULT_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_DEPTH
) ();

  localparam int CW = count_width(FIFO_DEPTH);

  logic                  w_en;
  logic [FIFO_WIDTH-1:0] din;
  logic                  r_en;
  logic [FIFO_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic [CW-1:0]         count;

  // Producer/consumer side of the FIFO.
  modport master (
    output w_en, din, r_en,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
    input  wr_ack, overflow, underflow, count
  );

  // The FIFO itself.
  modport slave (
    input  w_en, din, r_en,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
    output wr_ack, overflow, underflow, count
  );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - single-clock simple dual-port storage with registered read
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write; the array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register clears on reset and holds its word when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO: pointers, occupancy count and status flags
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH      = DEFAULT_WIDTH,
  parameter int FIFO_DEPTH      = DEFAULT_DEPTH,
  parameter int ALMOST_FULL_TH  = FIFO_DEPTH - DEFAULT_ALMOST_FULL_MARGIN,
  parameter int ALMOST_EMPTY_TH = DEFAULT_ALMOST_EMPTY_TH
) (
  input  logic      clk,
  input  logic      rst,
  sync_fifo_if.slave fifo_if
);

  localparam int AW = addr_width(FIFO_DEPTH);
  localparam int CW = count_width(FIFO_DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_TH_C = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH_C = CW'(ALMOST_EMPTY_TH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_c;
  logic          empty_c;
  logic          wr_acc;
  logic          rd_acc;
  logic          dout_valid_q;
  logic          wr_ack_q;
  logic          overflow_q;
  logic          underflow_q;

  // Flags are pure decodes of the count register so they change with it.
  assign full_c  = (count_q == DEPTH_C);
  assign empty_c = (count_q == '0);

  // A write into a full FIFO or a read from an empty one is dropped; the
  // other half of a simultaneous request still proceeds.
  assign wr_acc = fifo_if.w_en && !full_c;
  assign rd_acc = fifo_if.r_en && !empty_c;

  // Occupancy moves only when exactly one side is accepted.
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; pointers wrap by overflowing their natural width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // One-cycle status pulses reporting what happened to last cycle's requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      dout_valid_q <= rd_acc;
      wr_ack_q     <= wr_acc;
      overflow_q   <= fifo_if.w_en && full_c;
      underflow_q  <= fifo_if.r_en && empty_c;
    end
  end

  // Read and write never address the same word in one cycle: equal pointers
  // mean empty (read blocked) or full (write blocked).
  fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (fifo_if.din),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (fifo_if.dout)
  );

  assign fifo_if.dout_valid   = dout_valid_q;
  assign fifo_if.wr_ack       = wr_ack_q;
  assign fifo_if.overflow     = overflow_q;
  assign fifo_if.underflow    = underflow_q;
  assign fifo_if.count        = count_q;
  assign fifo_if.full         = full_c;
  assign fifo_if.empty        = empty_c;
  assign fifo_if.almost_full  = (count_q >= AF_TH_C);
  assign fifo_if.almost_empty = (count_q <= AE_TH_C);

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 512, number of words; power of two, >= 4.
REQ-003 SHALL have parameter ALMOST_FULL_TH, default FIFO_DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY_TH, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port w_en  input  1  write request.
REQ-008 SHALL have port din  input  FIFO_WIDTH  write data.
REQ-009 SHALL have port r_en  input  1  read request.
REQ-010 SHALL have port dout  output  FIFO_WIDTH  registered read data.
REQ-011 SHALL have port dout_valid  output  1  dout holds a word popped the previous cycle.
REQ-012 SHALL have port full, empty  output  1 each  occupancy flags.
REQ-013 SHALL have port almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 SHALL have port wr_ack  output  1  previous-cycle write accepted.
REQ-015 SHALL have port overflow, underflow  output  1 each  previous-cycle request rejected.
REQ-016 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-017 Write SHALL be accepted iff w_en && !full; din stored at write pointer, pointer increments.
REQ-018 Read SHALL be accepted iff r_en && !empty; word at read pointer loaded into dout on that edge, pointer increments.
REQ-019 Read latency SHALL be one cycle: dout and dout_valid update at the edge following r_en sampled high.
REQ-020 dout SHALL hold its last value when no read is accepted; dout_valid SHALL be 1 only in the cycle after an accepted read.
REQ-021 Pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap from FIFO_DEPTH-1 to 0 without extra logic.
REQ-022 count SHALL be +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 Simultaneous w_en and r_en when full: only the read SHALL be accepted; overflow asserts next cycle; count decrements.
REQ-024 Simultaneous w_en and r_en when empty: only the write SHALL be accepted; underflow asserts next cycle; no read-through of din.
REQ-025 Simultaneous accepted w_en and r_en at 0<count<DEPTH: both SHALL proceed, count unchanged.
REQ-026 full = (count == FIFO_DEPTH); empty = (count == 0); both SHALL be combinational from the count register.
REQ-027 almost_full = (count >= ALMOST_FULL_TH); almost_empty = (count <= ALMOST_EMPTY_TH); combinational from count.
REQ-028 wr_ack, overflow, underflow SHALL be registered, one-cycle pulses.

Reset
REQ-029 rst high SHALL immediately clear pointers, count, dout, dout_valid, wr_ack, overflow, underflow to 0.
REQ-030 During and after reset, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-032 Requests sampled on the first edge after rst deasserts SHALL be processed normally.

Structure
REQ-033 Shared package fifo_pkg SHALL hold the address-width and count-width derivation and flag-threshold defaults.
REQ-034 Storage SHALL be one sub-module, fifo_ram: single-clock simple dual-port array, synchronous write, registered read, no reset on the array.
REQ-035 Pointer, count and flag control SHALL live in sync_fifo itself.

Verification (FIFO_WIDTH=8, FIFO_DEPTH=8, ALMOST_FULL_TH=6, ALMOST_EMPTY_TH=2)
REQ-036 Write 0x01..0x08 then read 8 -> dout 0x01..0x08 in order, each one cycle after r_en; full at count 8, empty after last read.
REQ-037 Ninth write when full -> wr_ack=0, overflow=1 one cycle, count stays 8, data unchanged.
REQ-038 r_en on empty after reset -> underflow=1 one cycle, dout=0x00, dout_valid=0.
REQ-039 Fill to 8, then w_en+r_en together -> read returns oldest word, overflow=1, count=7; at count 4, w_en+r_en -> count stays 4, wr_ack=1.
REQ-040 20 writes and 20 reads interleaved across pointer wrap -> data order preserved; almost_full at count 6, almost_empty at count 2.
REQ-041 Assert rst with count=5 -> count=0, empty=1, dout=0 without a clock edge; next write then read returns new data.
